amo_wr_buffer: RTL and testbench
================================

AMO_WR_BUFFER -- requirements
Module: amo_wr_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; power of two, DEPTH >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 arst_n  input  1  asynchronous, active-low reset.
REQ-004 amo_mem_wr_req  input  1  AMO write request from the memory stage.
REQ-005 mask  input  4  byte-enable mask of the request.
REQ-006 core_out_mem_addr_in  input  32  request byte address.
REQ-007 core_out_mem_data_in  input  32  request write data.
REQ-008 stall  output  1  holds the pipeline; request not accepted this cycle.
REQ-009 shm_req  output  1  write request to shared memory.
REQ-010 shm_gnt  input  1  shared-memory grant; a transfer completes on shm_req & shm_gnt.
REQ-011 shm_addr / shm_wdata / shm_mask  output  32/32/4  head-entry payload.
REQ-012 chk_addr  input  32  load address from the memory stage, for hazard check.
REQ-013 rd_hazard  output  1  a buffered write targets the chk_addr word.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage: circular FIFO; read/write pointers $clog2(DEPTH)+1 bits wide; wrap via the MSB.
REQ-016 Empty: pointers equal. Full: index bits equal and MSBs differ.
REQ-017 Enqueue: amo_mem_wr_req & !full; entry = {addr, data, mask}; write pointer +1.
REQ-018 Full: the request is not accepted and stall = 1, even if a dequeue occurs in the same cycle; the request retries next cycle.
REQ-019 stall = amo_mem_wr_req & full; otherwise 0.
REQ-020 shm_req = !empty; shm_* payload = head entry, held stable until granted.
REQ-021 Dequeue: shm_req & shm_gnt; read pointer +1.
REQ-022 shm_gnt with shm_req = 0 is ignored.
REQ-023 Simultaneous enqueue and dequeue (not full): both happen; count unchanged.
REQ-024 Latency (macro absent): a request accepted in cycle N raises shm_req in N+1 at the earliest.
REQ-025 Ordering: strict FIFO; no merging, no reordering.
REQ-026 rd_hazard = OR over valid entries of (entry.addr[31:2] == chk_addr[31:2] & |entry.mask); the check is combinational.
REQ-027 count = write pointer − read pointer, modulo 2^($clog2(DEPTH)+1).
REQ-028 A request with mask = 4'b0000 is still enqueued and written; it never triggers a hazard.

Reset
REQ-029 While arst_n = 0: pointers = 0, count = 0, shm_req = 0, stall = 0, rd_hazard = 0.
REQ-030 Reset mid-transfer discards all entries; no shm_req after release until a new enqueue.
REQ-031 Entry storage is not reset; contents are unobservable while invalid.

Configuration
REQ-032 Macro AMO_WR_BYPASS_EN.
REQ-033 Defined, when empty & amo_mem_wr_req:
  - shm_req = 1 combinationally; shm_* driven from the inputs.
  - With shm_gnt = 1 in that cycle, the write completes and nothing is enqueued.
  - Otherwise the request is enqueued normally.
  - rd_hazard also covers the bypassed request.
REQ-034 Undefined: no bypass path; REQ-020 and REQ-024 apply unconditionally.

Structure
REQ-035 mem_stage_pkg holds:
  - amo_wr_entry_t packed struct {addr[31:0], data[31:0], mask[3:0]}
  - AMO_WR_BUF_DEPTH constant = 4
REQ-036 One sub-module, amo_wr_fifo: generic FIFO storage and pointers. The hazard compare, stall and bypass logic stay in amo_wr_buffer.

Verification
REQ-037 Single write, shm_gnt tied 1, macro off: addr 0x100, data 0xDEADBEEF, mask 0xF in cycle 0 -> shm_req = 1 with that payload in cycle 1; count back to 0 in cycle 2.
REQ-038 Fill, shm_gnt = 0, DEPTH = 4: 5 consecutive requests -> count = 4; stall = 1 on the 5th; raise shm_gnt -> 5th accepted the following cycle; drain order A, B, C, D, E.
REQ-039 Simultaneous: count = 2, enqueue + grant in the same cycle -> count stays 2; head advances one entry.
REQ-040 Hazard: buffered addr 0x204, mask 0x3; chk_addr 0x206 -> rd_hazard = 1; chk_addr 0x208 -> 0; buffered mask 0x0 -> 0.
REQ-041 Reset: 3 entries pending, arst_n low mid-cycle -> shm_req = 0 and count = 0 immediately; no writes after release.
REQ-042 AMO_WR_BYPASS_EN defined, empty, shm_gnt = 1: request 0x300 -> shm_req = 1 in the same cycle; count remains 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: AMO write-buffer entry and default depth.
package mem_stage_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } amo_wr_entry_t;

  localparam int unsigned AMO_WR_BUF_DEPTH = 4;

endpackage

// File: rtl/amo_wr_fifo.sv
// Generic circular FIFO of AMO write entries; exposes all slots and their
// validity so the parent can run an address-hazard compare.
module amo_wr_fifo import mem_stage_pkg::*; #(
  parameter int unsigned Depth = AMO_WR_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  amo_wr_entry_t                wdata_i,
  output amo_wr_entry_t                head_o,
  output amo_wr_entry_t [Depth-1:0]    entries_o,
  output logic [Depth-1:0]             valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth):0]       count_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [IdxW:0] wr_ptr_q, wr_ptr_d;
  logic [IdxW:0] rd_ptr_q, rd_ptr_d;
  amo_wr_entry_t [Depth-1:0] mem_q, mem_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{IdxW{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{IdxW{1'b0}}, pop_i};
    mem_d    = mem_q;
    if (push_i) begin
      mem_d[wr_ptr_q[IdxW-1:0]] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left unreset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                     (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
  assign head_o    = mem_q[rd_ptr_q[IdxW-1:0]];
  assign entries_o = mem_q;

  // A slot is valid when its distance from the read index is below count.
  for (genvar i = 0; i < Depth; i++) begin : g_valid
    logic [IdxW-1:0] offset;
    assign offset     = IdxW'(i) - rd_ptr_q[IdxW-1:0];
    assign valid_o[i] = ({1'b0, offset} < count_o);
  end

endmodule

// File: rtl/amo_wr_buffer.sv
// AMO write buffer between the memory stage and shared memory.
// Optional same-cycle bypass when empty: define AMO_WR_BYPASS_EN.
module amo_wr_buffer import mem_stage_pkg::*; #(
  parameter int unsigned DEPTH = AMO_WR_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    amo_mem_wr_req,
  input  logic [3:0]              mask,
  input  logic [31:0]             core_out_mem_addr_in,
  input  logic [31:0]             core_out_mem_data_in,
  output logic                    stall,
  output logic                    shm_req,
  input  logic                    shm_gnt,
  output logic [31:0]             shm_addr,
  output logic [31:0]             shm_wdata,
  output logic [3:0]              shm_mask,
  input  logic [31:0]             chk_addr,
  output logic                    rd_hazard,
  output logic [$clog2(DEPTH):0]  count
);

  amo_wr_entry_t             req_entry;
  amo_wr_entry_t             head;
  amo_wr_entry_t             out_entry;
  amo_wr_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]          valid;
  logic                      full, empty, push, pop, bypass;

  assign req_entry = '{addr: core_out_mem_addr_in, data: core_out_mem_data_in, mask: mask};

`ifdef AMO_WR_BYPASS_EN
  assign bypass = empty & amo_mem_wr_req;
`else
  assign bypass = 1'b0;
`endif

  // A granted bypass completes immediately, so it must not also be queued.
  assign push    = amo_mem_wr_req & ~full & ~(bypass & shm_gnt);
  assign pop     = ~empty & shm_gnt;
  assign stall   = amo_mem_wr_req & full;
  assign shm_req = ~empty | bypass;

  always_comb begin
    out_entry = bypass ? req_entry : head;
    shm_addr  = out_entry.addr;
    shm_wdata = out_entry.data;
    shm_mask  = out_entry.mask;
  end

  always_comb begin
    rd_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (entries[i].addr[31:2] == chk_addr[31:2]) && |entries[i].mask) begin
        rd_hazard = 1'b1;
      end
    end
    if (bypass && (req_entry.addr[31:2] == chk_addr[31:2]) && |req_entry.mask) begin
      rd_hazard = 1'b1;
    end
  end

  logic [DEPTH-1:0] unused_entry_bits;
  logic             unused_chk_lsb;
  for (genvar i = 0; i < DEPTH; i++) begin : g_unused
    assign unused_entry_bits[i] = ^{entries[i].data, entries[i].addr[1:0]};
  end
  assign unused_chk_lsb = ^chk_addr[1:0];

  amo_wr_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push_i    (push),
    .pop_i     (pop),
    .wdata_i   (req_entry),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (valid),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

endmodule

// File: tb/tb_amo_wr_buffer.sv
// Directed self-checking bench for amo_wr_buffer (DEPTH = 4).
module tb_amo_wr_buffer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic        gnt = 1'b0;
  logic [31:0] chk = '0;
  logic        stall, shm_req, rd_hazard;
  logic [31:0] shm_addr, shm_wdata;
  logic [3:0]  shm_mask;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  amo_wr_buffer #(.DEPTH(4)) dut (
    .clk                  (clk),
    .arst_n               (arst_n),
    .amo_mem_wr_req       (req),
    .mask                 (mask),
    .core_out_mem_addr_in (addr),
    .core_out_mem_data_in (data),
    .stall                (stall),
    .shm_req              (shm_req),
    .shm_gnt              (gnt),
    .shm_addr             (shm_addr),
    .shm_wdata            (shm_wdata),
    .shm_mask             (shm_mask),
    .chk_addr             (chk),
    .rd_hazard            (rd_hazard),
    .count                (count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    req  = r;
    addr = a;
    data = d;
    mask = m;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    #3;
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0 || stall !== 1'b0 || rd_hazard !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: count=%0d shm_req=%b stall=%b hz=%b expected 0/0/0/0",
               count, shm_req, stall, rd_hazard);
    end
    @(negedge clk);
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    gnt = 1'b1;
    drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    #1;
    tests++;
    if (shm_req !== 1'b0) begin
      fails++;
      $display("FAIL single_latency: shm_req=%b expected 0 in accept cycle", shm_req);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (shm_req !== 1'b1 || shm_addr !== 32'h100 || shm_wdata !== 32'hDEADBEEF ||
        shm_mask !== 4'hF || count !== 3'd1) begin
      fails++;
      $display("FAIL single_payload: req=%b addr=%h data=%h mask=%h count=%0d expected 1/100/deadbeef/f/1",
               shm_req, shm_addr, shm_wdata, shm_mask, count);
    end
    tick();
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: count=%0d shm_req=%b expected 0/0", count, shm_req);
    end
    gnt = 1'b0;
  endtask

  task automatic test_fill;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h10 * (i + 1), 32'hA0 + i, 4'hF);
      tick();
    end
    drive(1'b1, 32'h50, 32'hA4, 4'hF);
    #1;
    tests++;
    if (stall !== 1'b1 || count !== 3'd4 || shm_addr !== 32'h10) begin
      fails++;
      $display("FAIL fill_full: stall=%b count=%0d head=%h expected 1/4/10", stall, count, shm_addr);
    end
    tick();
    tests++;
    if (stall !== 1'b1 || count !== 3'd4) begin
      fails++;
      $display("FAIL fill_retry: stall=%b count=%0d expected 1/4", stall, count);
    end
    gnt = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b1 || shm_addr !== 32'h10) begin
      fails++;
      $display("FAIL fill_full_dequeue: stall=%b head=%h expected 1/10", stall, shm_addr);
    end
    tick();
    tests++;
    if (stall !== 1'b0 || count !== 3'd3 || shm_addr !== 32'h20) begin
      fails++;
      $display("FAIL fill_accept: stall=%b count=%0d head=%h expected 0/3/20", stall, count, shm_addr);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    for (int i = 2; i < 5; i++) begin
      tests++;
      if (shm_req !== 1'b1 || shm_addr !== 32'h10 * (i + 1) || shm_wdata !== 32'hA0 + i) begin
        fails++;
        $display("FAIL fill_order[%0d]: req=%b addr=%h data=%h expected 1/%h/%h",
                 i, shm_req, shm_addr, shm_wdata, 32'h10 * (i + 1), 32'hA0 + i);
      end
      tick();
    end
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0) begin
      fails++;
      $display("FAIL fill_drained: count=%0d shm_req=%b expected 0/0", count, shm_req);
    end
    gnt = 1'b0;
  endtask

  task automatic test_simultaneous;
    gnt = 1'b0;
    drive(1'b1, 32'h60, 32'h1, 4'hF);
    tick();
    drive(1'b1, 32'h64, 32'h2, 4'hF);
    tick();
    drive(1'b1, 32'h68, 32'h3, 4'hF);
    #1;
    tests++;
    if (count !== 3'd2 || shm_addr !== 32'h60) begin
      fails++;
      $display("FAIL simul_pre: count=%0d head=%h expected 2/60", count, shm_addr);
    end
    gnt = 1'b1;
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (count !== 3'd2 || shm_addr !== 32'h64) begin
      fails++;
      $display("FAIL simul_post: count=%0d head=%h expected 2/64", count, shm_addr);
    end
    tick();
    tick();
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL simul_drain: count=%0d expected 0", count);
    end
    gnt = 1'b0;
  endtask

  task automatic test_hazard;
    gnt = 1'b0;
    drive(1'b1, 32'h204, 32'h11, 4'h3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    chk = 32'h206;
    #1;
    tests++;
    if (rd_hazard !== 1'b1) begin
      fails++;
      $display("FAIL hazard_same_word: rd_hazard=%b expected 1", rd_hazard);
    end
    chk = 32'h208;
    #1;
    tests++;
    if (rd_hazard !== 1'b0) begin
      fails++;
      $display("FAIL hazard_next_word: rd_hazard=%b expected 0", rd_hazard);
    end
    drive(1'b1, 32'h208, 32'h22, 4'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (rd_hazard !== 1'b0 || count !== 3'd2) begin
      fails++;
      $display("FAIL hazard_zero_mask: rd_hazard=%b count=%0d expected 0/2", rd_hazard, count);
    end
    chk = 32'h206;
    gnt = 1'b1;
    #1;
    tests++;
    if (rd_hazard !== 1'b1) begin
      fails++;
      $display("FAIL hazard_second_slot: rd_hazard=%b expected 1", rd_hazard);
    end
    tick();
    tick();
    tests++;
    if (rd_hazard !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL hazard_cleared: rd_hazard=%b count=%0d expected 0/0", rd_hazard, count);
    end
    gnt = 1'b0;
    chk = 32'h0;
  endtask

  task automatic test_reset_mid;
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 4 * i, 32'h50 + i, 4'hF);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (count !== 3'd3 || shm_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: count=%0d shm_req=%b expected 3/1", count, shm_req);
    end
    #2;
    arst_n = 1'b0;
    #1;
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: count=%0d shm_req=%b expected 0/0", count, shm_req);
    end
    @(negedge clk);
    arst_n = 1'b1;
    gnt = 1'b1;
    tick();
    tick();
    tick();
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_release: count=%0d shm_req=%b expected 0/0", count, shm_req);
    end
    gnt = 1'b0;
  endtask

`ifdef AMO_WR_BYPASS_EN
  task automatic test_bypass;
    gnt = 1'b1;
    drive(1'b1, 32'h300, 32'h33, 4'hF);
    chk = 32'h302;
    #1;
    tests++;
    if (shm_req !== 1'b1 || shm_addr !== 32'h300 || shm_wdata !== 32'h33 ||
        count !== 3'd0 || rd_hazard !== 1'b1) begin
      fails++;
      $display("FAIL bypass_same_cycle: req=%b addr=%h data=%h count=%0d hz=%b expected 1/300/33/0/1",
               shm_req, shm_addr, shm_wdata, count, rd_hazard);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (count !== 3'd0 || shm_req !== 1'b0) begin
      fails++;
      $display("FAIL bypass_not_queued: count=%0d shm_req=%b expected 0/0", count, shm_req);
    end
    gnt = 1'b0;
    chk = 32'h0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef AMO_WR_BYPASS_EN
    test_bypass();
`else
    test_single();
`endif
    test_fill();
    test_simultaneous();
    test_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
